// File: rtl/row_buffer_system.sv
// Line-buffer front end: fetches a square raster image and stores the last RB_COUNT rows in one
// circular RAM. Define RB_FRAME_LOOP_EN to refetch frames continuously instead of halting.
module row_buffer_system #(
  parameter int PIXEL_BITS   = 8,
  parameter int IMAGE_WIDTH  = 512,
  parameter int KERNEL_SIZE  = 5,
  parameter int RB_COUNT     = KERNEL_SIZE - 1,
  parameter int STALL_CYCLES = 1,
  localparam int AW = $clog2(IMAGE_WIDTH * IMAGE_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           ext_rd_en,
  output logic [AW-1:0]                  ext_rd_addr,
  input  logic [PIXEL_BITS-1:0]          ext_data_in,
  input  logic                           ext_data_valid,
  output logic [PIXEL_BITS*RB_COUNT-1:0] rb_read_data,
  output logic [RB_COUNT-1:0]            rb_pixel_valid
);

  localparam int MEM_DEPTH = RB_COUNT * IMAGE_WIDTH;
  localparam int MW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int SW  = (RB_COUNT > 1) ? $clog2(RB_COUNT) : 1;
  localparam int STW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

  localparam logic [AW-1:0]  ADDR_LAST  = AW'(IMAGE_WIDTH * IMAGE_WIDTH - 1);
  localparam logic [CW-1:0]  COL_LAST   = CW'(IMAGE_WIDTH - 1);
  localparam logic [SW-1:0]  SLOT_LAST  = SW'(RB_COUNT - 1);
  localparam logic [STW-1:0] STALL_LAST = STW'(STALL_CYCLES - 1);

  typedef enum logic [1:0] {F_IDLE, F_FETCH, F_STALL, F_DONE} fetch_state_e;

  // ---------------------------------------------------------------- fetch side
  fetch_state_e   state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [CW-1:0]  col_q, col_d;
  logic [STW-1:0] stall_q, stall_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= F_IDLE;
      addr_q  <= '0;
      col_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      stall_q <= stall_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    col_d     = col_q;
    stall_d   = stall_q;
    ext_rd_en = 1'b0;
    unique case (state_q)
      F_IDLE: state_d = F_FETCH;
      F_FETCH: begin
        ext_rd_en = 1'b1;
        addr_d    = addr_q + 1'b1;
        col_d     = col_q + 1'b1;
        if (col_q == COL_LAST) begin
          col_d   = '0;
          state_d = (STALL_CYCLES == 0) ? F_FETCH : F_STALL;
          if (addr_q == ADDR_LAST) begin
            addr_d = '0;
`ifndef RB_FRAME_LOOP_EN
            state_d = F_DONE;
`endif
          end
        end
      end
      F_STALL: begin
        if (stall_q == STALL_LAST) begin
          stall_d = '0;
          state_d = F_FETCH;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      F_DONE: state_d = F_DONE;
      default: state_d = F_IDLE;
    endcase
  end

  assign ext_rd_addr = addr_q;

  // ---------------------------------------------------------------- write side
  logic [CW-1:0] w_col_q, w_col_d;
  logic [SW-1:0] w_slot_q, w_slot_d;
  logic          filled_q, filled_d;
  logic          en_r;
  logic [MW-1:0] w_addr;

`ifdef RB_FRAME_LOOP_EN
  logic [CW-1:0] w_row_q, w_row_d;
`endif

  assign en_r   = ext_data_valid & filled_q;
  assign w_addr = MW'(int'(w_slot_q) * IMAGE_WIDTH + int'(w_col_q));

  always_comb begin
    w_col_d  = w_col_q;
    w_slot_d = w_slot_q;
    filled_d = filled_q;
`ifdef RB_FRAME_LOOP_EN
    w_row_d  = w_row_q;
`endif
    if (ext_data_valid) begin
      w_col_d = w_col_q + 1'b1;
      if (w_col_q == COL_LAST) begin
        w_col_d = '0;
        if (w_slot_q == SLOT_LAST) begin
          w_slot_d = '0;
          filled_d = 1'b1;
        end else begin
          w_slot_d = w_slot_q + 1'b1;
        end
`ifdef RB_FRAME_LOOP_EN
        // The last pixel of a frame restarts the buffer so rows never span two frames.
        w_row_d = w_row_q + 1'b1;
        if (w_row_q == COL_LAST) begin
          w_row_d  = '0;
          w_slot_d = '0;
          filled_d = 1'b0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_col_q  <= '0;
      w_slot_q <= '0;
      filled_q <= 1'b0;
`ifdef RB_FRAME_LOOP_EN
      w_row_q  <= '0;
`endif
    end else begin
      w_col_q  <= w_col_d;
      w_slot_q <= w_slot_d;
      filled_q <= filled_d;
`ifdef RB_FRAME_LOOP_EN
      w_row_q  <= w_row_d;
`endif
    end
  end

  // ---------------------------------------------------------------- storage
  logic [PIXEL_BITS-1:0] mem_q [MEM_DEPTH];

  // NOTE: the row RAM is not reset; stale words are never emitted because reads wait for the fill flag.
  always_ff @(posedge clk) begin
    if (ext_data_valid) mem_q[w_addr] <= ext_data_in;
  end

  // Reads see pre-write contents, so the slot being overwritten yields the oldest row in lane 0.
  logic [PIXEL_BITS*RB_COUNT-1:0] rd_lanes;
  always_comb begin
    rd_lanes = '0;
    for (int k = 0; k < RB_COUNT; k++) begin
      rd_lanes[k*PIXEL_BITS +: PIXEL_BITS] =
        mem_q[MW'(((int'(w_slot_q) + k) % RB_COUNT) * IMAGE_WIDTH + int'(w_col_q))];
    end
  end

  // ---------------------------------------------------------------- output register
  logic [PIXEL_BITS*RB_COUNT-1:0] rb_data_q;
  logic [RB_COUNT-1:0]            rb_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rb_data_q  <= '0;
      rb_valid_q <= '0;
    end else begin
      if (en_r) rb_data_q <= rd_lanes;
      rb_valid_q <= {RB_COUNT{en_r}};
    end
  end

  assign rb_read_data   = rb_data_q;
  assign rb_pixel_valid = rb_valid_q;

endmodule

// File: tb/tb_row_buffer_system.sv
// Directed bench for row_buffer_system on an 8x8 image; external memory returns addr%256.
// A second instance with STALL_CYCLES=0 checks the no-stall row boundary.
module tb_row_buffer_system;

  localparam int PB = 8;
  localparam int IW = 8;
  localparam int RC = 4;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          ext_rd_en, ext_rd_en0;
  logic [AW-1:0] ext_rd_addr, ext_rd_addr0;
  logic [PB-1:0] ext_data_in, ext_data_in0;
  logic          ext_data_valid, ext_data_valid0;
  logic [PB*RC-1:0] rb_read_data, rb_read_data0;
  logic [RC-1:0]    rb_pixel_valid, rb_pixel_valid0;

  always #5 clk = ~clk;

  // External memory model: same-cycle response, valid follows the request.
  assign ext_data_in     = {2'b00, ext_rd_addr};
  assign ext_data_valid  = ext_rd_en;
  assign ext_data_in0    = {2'b00, ext_rd_addr0};
  assign ext_data_valid0 = ext_rd_en0;

  row_buffer_system #(.PIXEL_BITS(PB), .IMAGE_WIDTH(IW), .KERNEL_SIZE(5),
                      .RB_COUNT(RC), .STALL_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .ext_rd_en(ext_rd_en), .ext_rd_addr(ext_rd_addr),
    .ext_data_in(ext_data_in), .ext_data_valid(ext_data_valid),
    .rb_read_data(rb_read_data), .rb_pixel_valid(rb_pixel_valid)
  );

  row_buffer_system #(.PIXEL_BITS(PB), .IMAGE_WIDTH(IW), .KERNEL_SIZE(5),
                      .RB_COUNT(RC), .STALL_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .ext_rd_en(ext_rd_en0), .ext_rd_addr(ext_rd_addr0),
    .ext_data_in(ext_data_in0), .ext_data_valid(ext_data_valid0),
    .rb_read_data(rb_read_data0), .rb_pixel_valid(rb_pixel_valid0)
  );

  int   n_vec = 0;
  int   n_err = 0;
  logic valid_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance until the main DUT requests `target`, noting any valid output on the way.
  task automatic wait_addr(input logic [AW-1:0] target, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (|rb_pixel_valid) valid_seen = 1'b1;
      if (ext_rd_en && ext_rd_addr == target) found = 1'b1;
    end
    check({"reach_", tag}, 64'(found), 64'd1);
  endtask

  // Expected lane vector, lane 0 in the low byte.
  function automatic logic [31:0] lanes(input int l0, l1, l2, l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  initial begin
    logic any_en, any_valid;

    // Reset for 5 cycles
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_en",    64'(ext_rd_en),      64'd0);
    check("rst_addr",  64'(ext_rd_addr),    64'd0);
    check("rst_data",  64'(rb_read_data),   64'd0);
    check("rst_valid", 64'(rb_pixel_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("first_en",   64'(ext_rd_en),   64'd1);
    check("first_addr", 64'(ext_rd_addr), 64'd0);

    // Row boundary: one stall cycle (main), none (dut0)
    valid_seen = 1'b0;
    wait_addr(6'd7, "a7");
    @(negedge clk);
    check("stall_en",       64'(ext_rd_en),    64'd0);
    check("nostall_en",     64'(ext_rd_en0),   64'd1);
    check("nostall_addr",   64'(ext_rd_addr0), 64'd8);
    @(negedge clk);
    check("after_stall_en",   64'(ext_rd_en),   64'd1);
    check("after_stall_addr", 64'(ext_rd_addr), 64'd8);

    // Fill: nothing valid until the first pixel of row 4 is accepted
    wait_addr(6'd32, "a32");
    check("fill_no_valid", 64'(valid_seen), 64'd0);
    @(negedge clk);
    check("a32_valid", 64'(rb_pixel_valid), 64'hF);
    check("a32_data",  64'(rb_read_data),   64'(lanes(0, 8, 16, 24)));

    wait_addr(6'd42, "a42");
    @(negedge clk);
    check("a42_valid", 64'(rb_pixel_valid), 64'hF);
    check("a42_data",  64'(rb_read_data),   64'(lanes(10, 18, 26, 34)));

    wait_addr(6'd63, "a63");
    @(negedge clk);
    check("a63_valid", 64'(rb_pixel_valid), 64'hF);
    check("a63_data",  64'(rb_read_data),   64'(lanes(31, 39, 47, 55)));

`ifdef RB_FRAME_LOOP_EN
    check("loop_stall_en", 64'(ext_rd_en), 64'd0);
    @(negedge clk);
    check("loop_en",   64'(ext_rd_en),   64'd1);
    check("loop_addr", 64'(ext_rd_addr), 64'd0);
    valid_seen = 1'b0;
    wait_addr(6'd32, "loop_a32");
    check("loop_fill_no_valid", 64'(valid_seen), 64'd0);
    @(negedge clk);
    check("loop_a32_valid", 64'(rb_pixel_valid), 64'hF);
    check("loop_a32_data",  64'(rb_read_data),   64'(lanes(0, 8, 16, 24)));
`else
    any_en = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ext_rd_en) any_en = 1'b1;
      if (|rb_pixel_valid) any_valid = 1'b1;
    end
    check("end_no_fetch", 64'(any_en),       64'd0);
    check("end_no_valid", 64'(any_valid),    64'd0);
    check("end_data_hold", 64'(rb_read_data), 64'(lanes(31, 39, 47, 55)));
`endif

    // Restart, then reset mid-frame at address 40
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("restart_addr", 64'(ext_rd_addr), 64'd0);
    wait_addr(6'd40, "a40");
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_en",    64'(ext_rd_en),      64'd0);
    check("mid_rst_valid", 64'(rb_pixel_valid), 64'd0);
    check("mid_rst_data",  64'(rb_read_data),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_first_en",   64'(ext_rd_en),   64'd1);
    check("mid_first_addr", 64'(ext_rd_addr), 64'd0);
    valid_seen = 1'b0;
    wait_addr(6'd32, "mid_a32");
    check("mid_fill_no_valid", 64'(valid_seen), 64'd0);
    @(negedge clk);
    check("mid_a32_valid", 64'(rb_pixel_valid), 64'hF);
    check("mid_a32_data",  64'(rb_read_data),   64'(lanes(0, 8, 16, 24)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
